// File: rtl/branch_resolve_queue_pkg.sv
// branch_resolve_queue_pkg: shared entry type and sizing constants for the branch resolve queue
package branch_resolve_queue_pkg;
  localparam int XLEN = 32;
  localparam int DEFAULT_DEPTH = 4;
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic pred;
    logic [XLEN-1:0] pred_target;
  } bq_entry_t;
endpackage

// File: rtl/branch_resolve_queue_bq_fifo.sv
// bq_fifo: circular entry store with wrapping pointers, occupancy count and single-cycle clear
module bq_fifo
  import branch_resolve_queue_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      push,
  input  logic      pop,
  input  logic      clear,
  input  bq_entry_t din,
  output bq_entry_t head,
  output logic      full,
  output logic      empty
);
  localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0] count;
  bq_entry_t mem [DEPTH];
  assign head = mem[rd_ptr];
  assign full = count == FULL;
  assign empty = count == '0;
  always_ff @(posedge clk)
    if (reset || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};
    end
  // storage is intentionally left uninitialised by reset
  always_ff @(posedge clk)
    if (push && !clear) mem[wr_ptr] <= din;
endmodule

// File: rtl/branch_resolve_queue.sv
// branch_resolve_queue: tracks in-flight predicted branches, resolves them in order and redirects fetch on mispredict
module branch_resolve_queue
  import branch_resolve_queue_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            enq_valid,
  input  logic [XLEN-1:0] enq_pc,
  input  logic            enq_pred,
  input  logic [XLEN-1:0] enq_pred_target,
  output logic            enq_ready,
  input  logic            res_valid,
  input  logic            res_taken,
  input  logic [XLEN-1:0] res_target,
  output logic            prev_branch_in,
  output logic [XLEN-1:0] prev_pc,
  output logic            prev_taken,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic [31:0]     br_count,
  output logic [31:0]     mispred_count,
  output logic            underflow_err
);
  bq_entry_t head;
  logic full, empty, enq_fire, res_act, res_fire, mispred;
  assign enq_ready = !full && !redirect_valid;
  assign enq_fire = enq_valid && enq_ready;
  assign res_act = res_valid && !redirect_valid;
  assign res_fire = res_act && !empty;
  assign mispred = res_fire && ((head.pred != res_taken) || (res_taken && head.pred_target != res_target));
  bq_fifo #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_fifo (
    .clk(clk),
    .reset(reset),
    .push(enq_fire && !mispred),
    .pop(res_fire),
    .clear(mispred),
    .din('{pc: enq_pc, pred: enq_pred, pred_target: enq_pred_target}),
    .head(head),
    .full(full),
    .empty(empty)
  );
  always_ff @(posedge clk)
    if (reset) begin
      prev_branch_in <= 1'b0;
      prev_pc <= '0;
      prev_taken <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc <= '0;
      br_count <= '0;
      mispred_count <= '0;
      underflow_err <= 1'b0;
    end else begin
      prev_branch_in <= res_fire;
      redirect_valid <= mispred;
      if (res_fire) begin
        prev_pc <= head.pc;
        prev_taken <= res_taken;
        br_count <= br_count + 32'd1;
      end
      if (mispred) begin
        redirect_pc <= res_taken ? res_target : head.pc + 32'd4;
        mispred_count <= mispred_count + 32'd1;
      end
      if (res_act && empty) underflow_err <= 1'b1;
    end
endmodule
